// File: rtl/stable_matching_pkg.sv
// Shared definitions for the stable-matching core and its preference loader:
// index-width math, packed-vector sizing and loader state encoding.
package stable_matching_pkg;

  typedef enum logic [1:0] {
    LOAD_B = 2'd0,
    LOAD_A = 2'd1,
    FULL   = 2'd2
  } ld_state_e;

  function automatic int log2c(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int calc_nb(input int r, input int kr);
    return r * kr;
  endfunction

  function automatic int calc_na(input int s, input int ks);
    return s * ks;
  endfunction

  // B entries index list A (logS bits each), A entries index list B (logR bits each).
  function automatic int calc_pw(input int s, input int r, input int ks, input int kr);
    return r * kr * log2c(s) + s * ks * log2c(r);
  endfunction

endpackage

// File: rtl/stable_matching_pref_loader.sv
// Streams range-checked preference entries into the flat p_input vector and
// holds it under a valid/ready handshake while the matching core evaluates.
module stable_matching_pref_loader
  import stable_matching_pkg::*;
#(
  parameter int Ks = 2,
  parameter int Kr = Ks,
  parameter int S  = 4,
  parameter int R  = S,
  localparam int logS = log2c(S),
  localparam int logR = log2c(R),
  localparam int IW   = max2(logS, logR),
  localparam int NB   = calc_nb(R, Kr),
  localparam int NA   = calc_na(S, Ks),
  localparam int PW   = calc_pw(S, R, Ks, Kr)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic [IW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [PW-1:0] p_input,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          err
);

  localparam int IdxW = log2c(max2(max2(NB, NA), 2));

  ld_state_e       state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [PW-1:0]   p_q, p_d;
  logic            err_q, err_d;
  logic            rdy_q, rdy_d;
  logic            accept;

  assign accept = in_valid & rdy_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    p_d     = p_q;
    err_d   = err_q;
    if (clear) begin
      state_d = LOAD_B;
      idx_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        LOAD_B: begin
          if (accept) begin
            p_d[int'(idx_q)*logS +: logS] = in_data[logS-1:0];
            if (32'(in_data) >= 32'(S)) err_d = 1'b1;
            if (idx_q == IdxW'(NB - 1)) begin
              state_d = LOAD_A;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end
        end
        LOAD_A: begin
          if (accept) begin
            p_d[NB*logS + int'(idx_q)*logR +: logR] = in_data[logR-1:0];
            if (32'(in_data) >= 32'(R)) err_d = 1'b1;
            if (idx_q == IdxW'(NA - 1)) begin
              state_d = FULL;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end
        end
        FULL: begin
          // p_q is kept; the next load overwrites every slot anyway.
          if (out_ready) begin
            state_d = LOAD_B;
            idx_d   = '0;
            err_d   = 1'b0;
          end
        end
        default: begin
          state_d = LOAD_B;
          idx_d   = '0;
        end
      endcase
    end
    rdy_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_B;
      idx_q   <= '0;
      p_q     <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      p_q     <= p_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign p_input   = p_q;
  assign out_valid = (state_q == FULL);
  assign err       = err_q;

endmodule
